// File: rtl/debouncer_pkg.sv
// -----------------------------------------------------------------------------
// debouncer_pkg
//   Shared constants and helpers for the multi-channel debouncer.
//   - GLITCH_CNT_W   : width of each per-channel glitch counter
//   - GLITCH_CNT_MAX : saturation value of the glitch counter
//   - cnt_width()    : width of a stability counter able to hold stable_clks
// -----------------------------------------------------------------------------
package debouncer_pkg;

  localparam int GLITCH_CNT_W = 8;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = 8'hFF;

  function automatic int cnt_width(input int stable_clks);
    return $clog2(stable_clks + 1);
  endfunction

endpackage : debouncer_pkg

// File: rtl/debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
//   One debouncer channel: synchronizer -> stability counter -> registered
//   clean level with registered rise/fall pulses, plus an optional saturating
//   glitch counter (built only when DEBOUNCER_GLITCH_CNT_EN is defined).
//
// Ports
//   clk        in  1             clock
//   rst_n      in  1             asynchronous, active-low reset
//   tick       in  1             count enable
//   noisy_in   in  1             raw asynchronous input
//   glitch_clr in  1             synchronous clear of the glitch counter
//   db_out     out 1             debounced level
//   rise       out 1             1-cycle pulse on db_out 0->1
//   fall       out 1             1-cycle pulse on db_out 1->0
//   glitch_cnt out GLITCH_CNT_W  saturating count of aborted qualifications
// -----------------------------------------------------------------------------
module debounce_chan
  import debouncer_pkg::*;
#(
  parameter int STABLE_CLKS = 16,
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    noisy_in,
  input  logic                    glitch_clr,
  output logic                    db_out,
  output logic                    rise,
  output logic                    fall,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

  localparam int              CNT_W    = cnt_width(STABLE_CLKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CLKS - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  // Oldest synchronizer stage is the only one safe to use in logic.
  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], noisy_in};
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s == db_q) begin
      // Input agrees with the accepted level: any partial qualification is
      // abandoned, independent of tick.
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CNT_LAST) begin
        db_d   = s;
        cnt_d  = '0;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      cnt_q  <= '0;
      db_q   <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign db_out = db_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

`ifdef DEBOUNCER_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;
  logic                    glitch_evt;

  // A glitch is a qualification that was in progress and got aborted.
  assign glitch_evt = (s == db_q) && (cnt_q != '0);

  always_comb begin
    glitch_d = glitch_q;
    if (glitch_clr) begin
      glitch_d = '0;
    end else if (glitch_evt && (glitch_q != GLITCH_CNT_MAX)) begin
      glitch_d = glitch_q + GLITCH_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`else
  // Feature not built: keep the port, ignore the clear.
  logic unused_glitch_clr;
  assign unused_glitch_clr = glitch_clr;
  assign glitch_cnt        = '0;
`endif

endmodule : debounce_chan

// File: rtl/debouncer_multi.sv
// -----------------------------------------------------------------------------
// debouncer_multi
//   N-channel counter-based debouncer. Each channel is an independent
//   debounce_chan; all channels share clk, rst_n, tick and glitch_clr.
//   Optional glitch counters are enabled by defining DEBOUNCER_GLITCH_CNT_EN.
//
// Ports
//   clk        in  1           clock
//   rst_n      in  1           asynchronous, active-low reset
//   tick       in  1           count enable (tie 1'b1 to count every clk)
//   noisy_in   in  CHANNELS    raw asynchronous inputs
//   db_out     out CHANNELS    debounced levels
//   rise       out CHANNELS    1-cycle pulse per channel on 0->1
//   fall       out CHANNELS    1-cycle pulse per channel on 1->0
//   glitch_clr in  1           synchronous clear of all glitch counters
//   glitch_cnt out 8*CHANNELS  per-channel glitch count, ch i = [8i+7:8i]
// -----------------------------------------------------------------------------
module debouncer_multi
  import debouncer_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int STABLE_CLKS = 16,
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tick,
  input  logic [CHANNELS-1:0]              noisy_in,
  output logic [CHANNELS-1:0]              db_out,
  output logic [CHANNELS-1:0]              rise,
  output logic [CHANNELS-1:0]              fall,
  input  logic                             glitch_clr,
  output logic [GLITCH_CNT_W*CHANNELS-1:0] glitch_cnt
);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    debounce_chan #(
      .STABLE_CLKS (STABLE_CLKS),
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (RST_VAL)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .noisy_in   (noisy_in[gi]),
      .glitch_clr (glitch_clr),
      .db_out     (db_out[gi]),
      .rise       (rise[gi]),
      .fall       (fall[gi]),
      .glitch_cnt (glitch_cnt[GLITCH_CNT_W*gi +: GLITCH_CNT_W])
    );
  end

endmodule : debouncer_multi

// File: tb/tb_debouncer_multi.sv
// -----------------------------------------------------------------------------
// tb_debouncer_multi
//   Directed self-checking bench for debouncer_multi (defaults: 4 channels,
//   STABLE_CLKS=16, SYNC_STAGES=2, RST_VAL=0) plus a 1-channel instance with
//   STABLE_CLKS=1. Inputs change 1 time unit after a rising edge; outputs are
//   checked 1 time unit after the rising edge that should update them.
// -----------------------------------------------------------------------------
module tb_debouncer_multi;

`ifdef DEBOUNCER_GLITCH_CNT_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        glitch_clr;
  logic [3:0]  noisy_in;
  logic [3:0]  db_out, rise, fall;
  logic [31:0] glitch_cnt;

  logic        noisy1;
  logic        db1, rise1, fall1;
  logic [7:0]  gc1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  debouncer_multi u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .noisy_in   (noisy_in),
    .db_out     (db_out),
    .rise       (rise),
    .fall       (fall),
    .glitch_clr (glitch_clr),
    .glitch_cnt (glitch_cnt)
  );

  debouncer_multi #(.CHANNELS(1), .STABLE_CLKS(1)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .noisy_in   (noisy1),
    .db_out     (db1),
    .rise       (rise1),
    .fall       (fall1),
    .glitch_clr (glitch_clr),
    .glitch_cnt (gc1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Aborted qualification on ch0 (which sits at 1): low for 3 clks, high
  // for 3. The glitch is registered on the 6th edge.
  task automatic bounce0();
    noisy_in[0] = 1'b0;
    repeat (3) step();
    noisy_in[0] = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    rst_n      = 1'b0;
    tick       = 1'b1;
    glitch_clr = 1'b0;
    noisy_in   = 4'hF;
    noisy1     = 1'b0;

    // ---- 1: reset with all inputs high, then release ----
    repeat (3) step();
    chk("rst_db", db_out, 4'h0);
    chk("rst_rise", rise, 4'h0);
    chk("rst_fall", fall, 4'h0);
    chk("rst_gc", glitch_cnt, 32'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      chk("t1_db_hold", db_out, 4'h0);
      chk("t1_rise_hold", rise, 4'h0);
    end
    step();
    chk("t1_db_acc", db_out, 4'hF);
    chk("t1_rise_acc", rise, 4'hF);
    step();
    chk("t1_rise_off", rise, 4'h0);
    $display("t1: reset release, all channels rose after 18 clks");

    // ---- 2: ch0 to 0, bounce for 100 clks, settle at 1 ----
    noisy_in = 4'hE;
    repeat (17) step();
    chk("t2_pre_hold", db_out, 4'hF);
    step();
    chk("t2_pre_fall", fall, 4'h1);
    chk("t2_pre_db", db_out, 4'hE);
    for (int p = 0; p < 20; p++) begin
      noisy_in[0] = (p % 2 == 0);
      for (int k = 0; k < 5; k++) begin
        step();
        chk("t2_bounce_db", {31'b0, db_out[0]}, 32'h0);
        chk("t2_bounce_rise", {31'b0, rise[0]}, 32'h0);
      end
    end
    noisy_in[0] = 1'b1;
    repeat (17) step();
    chk("t2_settle_hold", {31'b0, db_out[0]}, 32'h0);
    step();
    chk("t2_settle_db", db_out, 4'hF);
    chk("t2_settle_rise", rise, 4'h1);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t2_single_rise", rise, 4'h0);
    end
    $display("t2: ch0 bounce ignored, single rise 18 clks after final edge");

    // ---- 3: ch1 1->0 ----
    noisy_in = 4'hD;
    for (int i = 1; i <= 17; i++) begin
      step();
      chk("t3_hold_db", db_out, 4'hF);
      chk("t3_hold_fall", fall, 4'h0);
    end
    step();
    chk("t3_fall", fall, 4'h2);
    chk("t3_rise", rise, 4'h0);
    chk("t3_db", db_out, 4'hD);
    step();
    chk("t3_fall_off", fall, 4'h0);
    $display("t3: ch1 fall after 18 clks");

    // ---- 4: ch2 to 0 with tick=1, then 0->1 with tick 1-in-4 ----
    noisy_in = 4'h9;
    repeat (18) step();
    chk("t4_pre_fall", fall, 4'h4);
    chk("t4_pre_db", db_out, 4'h9);
    step();
    noisy_in = 4'hD;
    for (int j = 1; j <= 64; j++) begin
      tick = (j % 4 == 0);
      step();
      if (j == 63) chk("t4_hold_db", db_out, 4'h9);
      if (j == 64) begin
        chk("t4_acc_db", db_out, 4'hD);
        chk("t4_acc_rise", rise, 4'h4);
      end
    end
    tick = 1'b1;
    step();
    chk("t4_rise_off", rise, 4'h0);
    $display("t4: ch2 accepted on 16th tick edge");

    // ---- 5: reset while ch3 has counted 10 ----
    noisy_in = 4'h5;
    repeat (12) step();
    chk("t5_pre_db", db_out, 4'hD);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_db", db_out, 4'h0);
    chk("t5_rst_rise", rise, 4'h0);
    chk("t5_rst_fall", fall, 4'h0);
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      chk("t5_hold_db", db_out, 4'h0);
      chk("t5_hold_pulse", {24'b0, rise, fall}, 32'h0);
    end
    step();
    chk("t5_acc_db", db_out, 4'h5);
    chk("t5_acc_rise", rise, 4'h5);
    chk("t5_acc_fall", fall, 4'h0);
    $display("t5: reset mid-qualification, fresh 18 clks after release");

    // ---- STABLE_CLKS=1 boundary ----
    noisy1 = 1'b1;
    repeat (2) step();
    chk("s1_hold", {31'b0, db1}, 32'h0);
    step();
    chk("s1_acc_db", {31'b0, db1}, 32'h1);
    chk("s1_acc_rise", {31'b0, rise1}, 32'h1);
    noisy1 = 1'b0;
    step();
    chk("s1_rise_off", {31'b0, rise1}, 32'h0);
    step();
    chk("s1_fall_hold", {31'b0, db1}, 32'h1);
    step();
    chk("s1_fall", {31'b0, fall1}, 32'h1);
    chk("s1_fall_db", {31'b0, db1}, 32'h0);
    $display("s1: STABLE_CLKS=1 accepts on first differing cycle");

    // ---- 6: glitch counter ----
    step();
    for (int b = 0; b < 10; b++) bounce0();
    chk("t6_gc_10", glitch_cnt, GC_EN ? 32'h0A : 32'h0);
    for (int b = 10; b < 300; b++) bounce0();
    chk("t6_gc_sat", glitch_cnt, GC_EN ? 32'hFF : 32'h0);
    chk("t6_db_kept", db_out, 4'h5);
    glitch_clr = 1'b1;
    step();
    glitch_clr = 1'b0;
    chk("t6_clr", glitch_cnt, 32'h0);
    bounce0();
    chk("t6_after_clr", glitch_cnt, GC_EN ? 32'h1 : 32'h0);
    noisy_in[0] = 1'b0;
    repeat (3) step();
    noisy_in[0] = 1'b1;
    repeat (2) step();
    glitch_clr = 1'b1;
    step();
    glitch_clr = 1'b0;
    chk("t6_clr_prio", glitch_cnt, 32'h0);
    bounce0();
    chk("t6_recount", glitch_cnt, GC_EN ? 32'h1 : 32'h0);
    $display("t6: glitch counter (enabled=%0d) saturation and clear", GC_EN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_debouncer_multi
